// File: rtl/fft64_pkg.sv
// Shared constants, types and twiddle-exponent helper for the 64-point FFT twiddle front end.
package fft64_pkg;
   localparam int N          = 64;
   localparam int LOG2N      = 6;
   localparam int NUM_BFLY   = 32;
   localparam int MAX_STAGE  = 5;
   localparam int COEF_IDX_W = 4;
   localparam int J_W        = 5;
   localparam int STAGE_W    = 3;

   typedef logic [LOG2N-1:0] twid_exp_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } seq_state_e;

   // k = (j mod 2^s) * 2^(5-s); only valid for s <= MAX_STAGE
   function automatic twid_exp_t twiddle_exp(input logic [J_W-1:0] j, input logic [STAGE_W-1:0] s);
      twid_exp_t mask;
      mask = twid_exp_t'((7'd1 << s) - 7'd1);
      return twid_exp_t'(({1'b0, j} & mask) << (3'd5 - s));
   endfunction
endpackage

// File: rtl/fft64_twiddle_map.sv
// Combinational twiddle exponent -> {octant code, base coefficient index 0..8}.
module fft64_twiddle_map
   import fft64_pkg::*;
(
   input  twid_exp_t               k_i,
   output logic [2:0]              typesel_o,
   output logic [COEF_IDX_W-1:0]   coef_idx_o
);
   always_comb begin
      typesel_o = k_i[5:3];
      // odd octants walk the base table backwards, so r=0 lands on entry 8
      if (k_i[3]) coef_idx_o = 4'd8 - {1'b0, k_i[2:0]};
      else        coef_idx_o = {1'b0, k_i[2:0]};
   end
endmodule

// File: rtl/fft64_twiddle_sequencer.sv
// Per-stage twiddle sequencer: tags 32 butterfly operands with octant/coef index.
// Optional FFT64_IFFT_CONJ_EN adds INVERSE for conjugate (IFFT) twiddles.
module fft64_twiddle_sequencer
   import fft64_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  START,
   input  logic [2:0]            STAGE,
`ifdef FFT64_IFFT_CONJ_EN
   input  logic                  INVERSE,
`endif
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [DATA_W-1:0]     IN_DATA,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [DATA_W-1:0]     OUT_DATA,
   output logic [2:0]            OUT_TYPESEL,
   output logic [COEF_IDX_W-1:0] OUT_COEF_IDX,
   output logic                  BUSY,
   output logic                  DONE
);
   seq_state_e              state_q, state_d;
   logic [J_W-1:0]          j_q, j_d;
   logic [STAGE_W-1:0]      stage_q, stage_d;
   logic                    vld_q, vld_d;
   logic [DATA_W-1:0]       data_q, data_d;
   logic [2:0]              ts_q, ts_d;
   logic [COEF_IDX_W-1:0]   ci_q, ci_d;
   logic                    done_q, done_d;
   twid_exp_t               k_fwd, k;
   logic [2:0]              map_ts;
   logic [COEF_IDX_W-1:0]   map_ci;
   logic                    in_ready, accept;

   assign k_fwd = twiddle_exp(j_q, stage_q);
`ifdef FFT64_IFFT_CONJ_EN
   logic inv_q, inv_d;
   assign k = inv_q ? twid_exp_t'(6'd0 - k_fwd) : k_fwd;
`else
   assign k = k_fwd;
`endif

   fft64_twiddle_map u_map (
      .k_i        (k),
      .typesel_o  (map_ts),
      .coef_idx_o (map_ci)
   );

   assign in_ready = (state_q == RUN) && (!vld_q || OUT_READY);
   assign accept   = in_ready && IN_VALID;

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      stage_d = stage_q;
      vld_d   = vld_q;
      data_d  = data_q;
      ts_d    = ts_q;
      ci_d    = ci_q;
      done_d  = 1'b0;
`ifdef FFT64_IFFT_CONJ_EN
      inv_d   = inv_q;
`endif
      if (vld_q && OUT_READY) vld_d = 1'b0;
      unique case (state_q)
         IDLE: if (START) begin
            stage_d = (STAGE > STAGE_W'(MAX_STAGE)) ? STAGE_W'(MAX_STAGE) : STAGE;
`ifdef FFT64_IFFT_CONJ_EN
            inv_d   = INVERSE;
`endif
            j_d     = '0;
            state_d = RUN;
         end
         RUN: if (accept) begin
            data_d = IN_DATA;
            ts_d   = map_ts;
            ci_d   = map_ci;
            vld_d  = 1'b1;
            j_d    = j_q + 5'd1;
            if (j_q == J_W'(NUM_BFLY - 1)) state_d = DRAIN;
         end
         DRAIN: if (!vld_q || OUT_READY) begin
            vld_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         j_q     <= '0;
         stage_q <= '0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         ts_q    <= '0;
         ci_q    <= '0;
         done_q  <= 1'b0;
`ifdef FFT64_IFFT_CONJ_EN
         inv_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         stage_q <= stage_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         ts_q    <= ts_d;
         ci_q    <= ci_d;
         done_q  <= done_d;
`ifdef FFT64_IFFT_CONJ_EN
         inv_q   <= inv_d;
`endif
      end
   end

   assign IN_READY     = in_ready;
   assign OUT_VALID    = vld_q;
   assign OUT_DATA     = data_q;
   assign OUT_TYPESEL  = ts_q;
   assign OUT_COEF_IDX = ci_q;
   assign BUSY         = (state_q != IDLE);
   assign DONE         = done_q;
endmodule

// File: tb/tb_fft64_twiddle_sequencer.sv
// Randomized bench for fft64_twiddle_sequencer against an arithmetic twiddle model.
module tb_fft64_twiddle_sequencer;
   logic        CLK = 1'b0;
   logic        RST_N, START, IN_VALID, IN_READY, OUT_VALID, OUT_READY, BUSY, DONE;
   logic [2:0]  STAGE, OUT_TYPESEL;
   logic [31:0] IN_DATA, OUT_DATA;
   logic [3:0]  OUT_COEF_IDX;
`ifdef FFT64_IFFT_CONJ_EN
   logic        INVERSE;
`endif

   int total = 0;
   int bad   = 0;
   logic [31:0] obs_data[32];
   int          obs_ts[32];
   int          obs_ci[32];

   always #5 CLK = ~CLK;

   fft64_twiddle_sequencer dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .STAGE(STAGE),
`ifdef FFT64_IFFT_CONJ_EN
      .INVERSE(INVERSE),
`endif
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
      .OUT_TYPESEL(OUT_TYPESEL), .OUT_COEF_IDX(OUT_COEF_IDX),
      .BUSY(BUSY), .DONE(DONE)
   );

   function automatic int ref_k(int j, int s, int inv);
      int ss, k;
      ss = (s > 5) ? 5 : s;
      k  = ((j % (1 << ss)) * (1 << (5 - ss))) % 64;
      if (inv != 0) k = (64 - k) % 64;
      return k;
   endfunction

   function automatic int ref_ts(int k);
      return k / 8;
   endfunction

   function automatic int ref_ci(int k);
      return ((k / 8) % 2 == 1) ? 8 - (k % 8) : k % 8;
   endfunction

   task automatic idle_checks(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         IN_VALID = 1'b1;
         IN_DATA  = $urandom;
         @(negedge CLK);
         total++;
         if ({DONE, BUSY, OUT_VALID, IN_READY} !== 4'b0000) begin
            bad++;
            $display("FAIL %s idle: done=%b busy=%b ov=%b ir=%b want all 0", nm, DONE, BUSY, OUT_VALID, IN_READY);
         end
         @(posedge CLK); #1;
      end
      IN_VALID = 1'b0;
   endtask

   // One stage pass; abort_at >= 0 resets the DUT after that many accepts.
   task automatic run_pass(input string nm, input int stg, input int inv, input int rdy_pct,
                           input int in_pct, input int abort_at, input bit chk_lat);
      logic [31:0] qd[$];
      int          qj[$];
      int          qc[$];
      int          acc = 0, outs = 0, cyc = 0, last_hs = -1;
      bit          fin = 0, stalled = 0;
      logic [31:0] sd, ed;
      logic [2:0]  sts;
      logic [3:0]  sci;
      int          ej, ec, ek;

      @(posedge CLK); #1;
      START     = 1'b1;
      STAGE     = 3'(stg);
`ifdef FFT64_IFFT_CONJ_EN
      INVERSE   = 1'(inv);
`endif
      IN_VALID  = 1'b1;
      IN_DATA   = $urandom;
      OUT_READY = 1'b1;
      @(negedge CLK);
      total++;
      if (IN_READY !== 1'b0) begin
         bad++;
         $display("FAIL %s start_cycle_ready: got %b want 0", nm, IN_READY);
      end
      @(posedge CLK); #1;

      while (!fin && cyc < 600) begin
         IN_VALID  = (acc < 32) ? (($urandom % 100) < in_pct) : 1'($urandom % 2);
         IN_DATA   = $urandom;
         OUT_READY = ($urandom % 100) < rdy_pct;
         START     = (acc < 32) ? ($urandom % 5 == 0) : 1'b0;
         STAGE     = 3'($urandom);
`ifdef FFT64_IFFT_CONJ_EN
         INVERSE   = 1'($urandom);
`endif
         @(negedge CLK);

         if (abort_at >= 0 && acc == abort_at) begin
            RST_N = 1'b0;
            #1;
            total++;
            if ({OUT_VALID, DONE, BUSY, IN_READY, OUT_DATA, OUT_TYPESEL, OUT_COEF_IDX} !== 43'd0) begin
               bad++;
               $display("FAIL %s abort_reset: ov=%b done=%b busy=%b ir=%b d=%h ts=%0d ci=%0d want all 0",
                        nm, OUT_VALID, DONE, BUSY, IN_READY, OUT_DATA, OUT_TYPESEL, OUT_COEF_IDX);
            end
            START = 1'b0;
            repeat (2) @(posedge CLK);
            #1 RST_N = 1'b1;
            idle_checks({nm, "_post_abort"}, 4);
            return;
         end

         total++;
         if (BUSY !== !DONE) begin
            bad++;
            $display("FAIL %s busy: got %b with done=%b", nm, BUSY, DONE);
         end
         if (stalled) begin
            total++;
            if ({OUT_VALID, OUT_DATA, OUT_TYPESEL, OUT_COEF_IDX} !== {1'b1, sd, sts, sci}) begin
               bad++;
               $display("FAIL %s stall_hold: got v=%b d=%h ts=%0d ci=%0d want v=1 d=%h ts=%0d ci=%0d",
                        nm, OUT_VALID, OUT_DATA, OUT_TYPESEL, OUT_COEF_IDX, sd, sts, sci);
            end
         end
         if (DONE === 1'b1) begin
            total++;
            if (OUT_VALID !== 1'b0 || outs != 32 || qd.size() != 0 || last_hs != cyc - 1) begin
               bad++;
               $display("FAIL %s done: ov=%b outs=%0d pending=%0d last_hs=%0d cyc=%0d want ov=0 outs=32 pending=0 last_hs=cyc-1",
                        nm, OUT_VALID, outs, qd.size(), last_hs, cyc);
            end
            fin = 1;
         end
         if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
            total++;
            if (qd.size() == 0) begin
               bad++;
               $display("FAIL %s extra_output: got d=%h want no output", nm, OUT_DATA);
            end else begin
               ed = qd.pop_front(); ej = qj.pop_front(); ec = qc.pop_front();
               ek = ref_k(ej, stg, inv);
               obs_data[ej] = OUT_DATA; obs_ts[ej] = int'(OUT_TYPESEL); obs_ci[ej] = int'(OUT_COEF_IDX);
               if (OUT_DATA !== ed || OUT_TYPESEL !== 3'(ref_ts(ek)) || OUT_COEF_IDX !== 4'(ref_ci(ek)) ||
                   (chk_lat && cyc != ec + 1)) begin
                  bad++;
                  $display("FAIL %s out j=%0d: got d=%h ts=%0d ci=%0d cyc=%0d want d=%h ts=%0d ci=%0d cyc=%0d",
                           nm, ej, OUT_DATA, OUT_TYPESEL, OUT_COEF_IDX, cyc, ed, ref_ts(ek), ref_ci(ek), ec + 1);
               end
            end
            outs++;
            last_hs = cyc;
         end
         stalled = (OUT_VALID === 1'b1 && OUT_READY === 1'b0);
         sd = OUT_DATA; sts = OUT_TYPESEL; sci = OUT_COEF_IDX;
         if (IN_VALID === 1'b1 && IN_READY === 1'b1) begin
            total++;
            if (acc >= 32) begin
               bad++;
               $display("FAIL %s extra_accept: got accept #%0d want at most 32", nm, acc + 1);
            end else begin
               qd.push_back(IN_DATA); qj.push_back(acc); qc.push_back(cyc);
            end
            acc++;
         end
         cyc++;
         @(posedge CLK); #1;
      end
      START = 1'b0;
      if (!fin) begin
         total++; bad++;
         $display("FAIL %s timeout: got no DONE after %0d cycles want DONE", nm, cyc);
      end
      idle_checks(nm, 3);
   endtask

   task automatic test_reset();
      RST_N = 1'b0; START = 1'b0; STAGE = 3'd0; IN_VALID = 1'b1; IN_DATA = 32'hdeadbeef; OUT_READY = 1'b1;
`ifdef FFT64_IFFT_CONJ_EN
      INVERSE = 1'b0;
`endif
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      total++;
      if ({OUT_VALID, DONE, BUSY, IN_READY, OUT_DATA, OUT_TYPESEL, OUT_COEF_IDX} !== 43'd0) begin
         bad++;
         $display("FAIL reset: ov=%b done=%b busy=%b ir=%b d=%h ts=%0d ci=%0d want all 0",
                  OUT_VALID, DONE, BUSY, IN_READY, OUT_DATA, OUT_TYPESEL, OUT_COEF_IDX);
      end
      @(posedge CLK); #1 RST_N = 1'b1;
      idle_checks("reset_idle", 3);
   endtask

   task automatic test_stage5();
      run_pass("stage5", 5, 0, 100, 100, -1, 1'b1);
      total++;
      if (obs_ts[9] != 1 || obs_ci[9] != 7 || obs_ts[8] != 1 || obs_ci[8] != 8) begin
         bad++;
         $display("FAIL stage5_points: got j9=%0d/%0d j8=%0d/%0d want j9=1/7 j8=1/8",
                  obs_ts[9], obs_ci[9], obs_ts[8], obs_ci[8]);
      end
   endtask

   task automatic test_stage3();
      run_pass("stage3", 3, 0, 100, 100, -1, 1'b1);
      total++;
      if (obs_ts[13] != 2 || obs_ci[13] != 4 || obs_ts[8] != 0 || obs_ci[8] != 0) begin
         bad++;
         $display("FAIL stage3_points: got j13=%0d/%0d j8=%0d/%0d want j13=2/4 j8=0/0",
                  obs_ts[13], obs_ci[13], obs_ts[8], obs_ci[8]);
      end
   endtask

   task automatic test_stage0();
      int nz = 0;
      run_pass("stage0", 0, 0, 100, 100, -1, 1'b1);
      for (int j = 0; j < 32; j++) if (obs_ts[j] != 0 || obs_ci[j] != 0) nz++;
      total++;
      if (nz != 0) begin
         bad++;
         $display("FAIL stage0_all_zero: got %0d nonzero entries want 0", nz);
      end
   endtask

   task automatic test_stall();
      for (int s = 0; s < 6; s++) run_pass("stall", s, 0, 50, 70, -1, 1'b0);
   endtask

   task automatic test_abort();
      run_pass("abort", 5, 0, 100, 100, 10, 1'b0);
      run_pass("after_abort", 5, 0, 100, 100, -1, 1'b1);
   endtask

   task automatic test_sat7();
      run_pass("stage7", 7, 0, 80, 90, -1, 1'b0);
      total++;
      if (obs_ts[9] != 1 || obs_ci[9] != 7) begin
         bad++;
         $display("FAIL stage7_sat: got j9=%0d/%0d want 1/7", obs_ts[9], obs_ci[9]);
      end
   endtask

`ifdef FFT64_IFFT_CONJ_EN
   task automatic test_inverse();
      run_pass("inverse", 5, 1, 100, 100, -1, 1'b1);
      total++;
      if (obs_ts[9] != 6 || obs_ci[9] != 7 || obs_ts[0] != 0 || obs_ci[0] != 0) begin
         bad++;
         $display("FAIL inverse_points: got j9=%0d/%0d j0=%0d/%0d want j9=6/7 j0=0/0",
                  obs_ts[9], obs_ci[9], obs_ts[0], obs_ci[0]);
      end
   endtask
`endif

   task automatic test_back_to_back();
      for (int p = 0; p < 4; p++) run_pass("b2b", int'($urandom_range(0, 7)), 0, 75, 85, -1, 1'b0);
   endtask

   initial begin
      test_reset();
      test_stage5();
      test_stage3();
      test_stage0();
      test_stall();
      test_abort();
      test_sat7();
`ifdef FFT64_IFFT_CONJ_EN
      test_inverse();
`endif
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
